// File: rtl/image_reconstructor.sv
// Streams a captured 6x8 halftone image as 48 gray pixels over a valid/ready handshake.
// Define RECON_FILTER_EN for 3x3 window averaging; otherwise pixels expand directly to 0/255.
module image_reconstructor (
   input  logic       clk,
   input  logic       reset,
   input  logic       Go,
   input  logic [1:8] HTPV_Row_1,
   input  logic [1:8] HTPV_Row_2,
   input  logic [1:8] HTPV_Row_3,
   input  logic [1:8] HTPV_Row_4,
   input  logic [1:8] HTPV_Row_5,
   input  logic [1:8] HTPV_Row_6,
   input  logic       pix_ready,
   output logic [7:0] pix_out,
   output logic       pix_valid,
   output logic [5:0] pix_index,
   output logic       busy,
   output logic       Done
);
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FINISH = 2'd2} state_t;

   state_t          state_r, state_s;
   logic [1:6][1:8] img_r, rows_s, src_s;
   logic [0:7][0:9] pad_s;
   logic [2:0]      row_r, row_s;
   logic [3:0]      col_r, col_s;
   logic [7:0]      gray_s, pix_out_s;
   logic [5:0]      pix_index_s;
   logic            pix_valid_s, busy_s, done_s, capture_s;

   assign rows_s = {HTPV_Row_1, HTPV_Row_2, HTPV_Row_3, HTPV_Row_4, HTPV_Row_5, HTPV_Row_6};
   // The first pixel is produced on the Go edge, before the image register is loaded.
   assign src_s  = (state_r == IDLE) ? rows_s : img_r;

   // Zero-bordered copy of the image so window reads never leave the array.
   always_comb begin
      pad_s = '0;
      for (int r = 1; r <= 6; r++) begin
         pad_s[r][1:8] = src_s[r];
      end
   end

   // Next raster position: (1,1) on start, advance on each accepted pixel except the last.
   always_comb begin
      row_s = row_r;
      col_s = col_r;
      if (state_r == IDLE && Go) begin
         row_s = 3'd1;
         col_s = 4'd1;
      end else if (state_r == SCAN && pix_ready && pix_index != 6'd48) begin
         if (col_r == 4'd8) begin
            row_s = row_r + 3'd1;
            col_s = 4'd1;
         end else begin
            col_s = col_r + 4'd1;
         end
      end else begin
         row_s = row_r;
         col_s = col_r;
      end
   end

`ifdef RECON_FILTER_EN
   function automatic logic [7:0] gray_lut(input logic [3:0] n, input logic [3:0] k);
      logic [7:0] g;
      case ({n, k})
         8'h40: g = 8'd0;   8'h41: g = 8'd63;  8'h42: g = 8'd127; 8'h43: g = 8'd191;
         8'h44: g = 8'd255;
         8'h60: g = 8'd0;   8'h61: g = 8'd42;  8'h62: g = 8'd85;  8'h63: g = 8'd127;
         8'h64: g = 8'd170; 8'h65: g = 8'd212; 8'h66: g = 8'd255;
         8'h90: g = 8'd0;   8'h91: g = 8'd28;  8'h92: g = 8'd56;  8'h93: g = 8'd85;
         8'h94: g = 8'd113; 8'h95: g = 8'd141; 8'h96: g = 8'd170; 8'h97: g = 8'd198;
         8'h98: g = 8'd226; 8'h99: g = 8'd255;
         default: g = 8'd0;
      endcase
      return g;
   endfunction

   logic [3:0] win_k_s, win_n_s;
   logic [2:0] win_r_s;
   logic [3:0] win_c_s;

   // Count white cells in the window and size the window by how many image edges it touches.
   always_comb begin
      win_k_s = 4'd0;
      win_r_s = 3'd0;
      win_c_s = 4'd0;
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            win_r_s = row_s + 3'(dr) - 3'd1;
            win_c_s = col_s + 4'(dc) - 4'd1;
            win_k_s = win_k_s + {3'd0, pad_s[win_r_s][win_c_s]};
         end
      end
      case ({row_s == 3'd1 || row_s == 3'd6, col_s == 4'd1 || col_s == 4'd8})
         2'b00:        win_n_s = 4'd9;
         2'b01, 2'b10: win_n_s = 4'd6;
         2'b11:        win_n_s = 4'd4;
         default:      win_n_s = 4'd9;
      endcase
      gray_s = gray_lut(win_n_s, win_k_s);
   end
`else
   // White expands to full scale, black to zero.
   always_comb begin
      gray_s = pad_s[row_s][col_s] ? 8'd255 : 8'd0;
   end
`endif

   // Next state and next registered outputs; outputs hold while a pixel is stalled.
   always_comb begin
      state_s     = state_r;
      capture_s   = 1'b0;
      pix_valid_s = pix_valid;
      pix_index_s = pix_index;
      pix_out_s   = pix_out;
      busy_s      = busy;
      done_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (Go) begin
               state_s     = SCAN;
               capture_s   = 1'b1;
               pix_valid_s = 1'b1;
               busy_s      = 1'b1;
               pix_index_s = 6'd1;
               pix_out_s   = gray_s;
            end else begin
               pix_valid_s = 1'b0;
               busy_s      = 1'b0;
               pix_index_s = 6'd0;
               pix_out_s   = 8'd0;
            end
         end
         SCAN: begin
            if (pix_ready && pix_index == 6'd48) begin
               state_s     = FINISH;
               pix_valid_s = 1'b0;
               busy_s      = 1'b0;
               pix_index_s = 6'd0;
               pix_out_s   = 8'd0;
               done_s      = 1'b1;
            end else if (pix_ready) begin
               pix_index_s = pix_index + 6'd1;
               pix_out_s   = gray_s;
            end else begin
               pix_index_s = pix_index;
               pix_out_s   = pix_out;
            end
         end
         FINISH: begin
            state_s     = IDLE;
            pix_valid_s = 1'b0;
            busy_s      = 1'b0;
            pix_index_s = 6'd0;
            pix_out_s   = 8'd0;
         end
         default: begin
            state_s     = IDLE;
            pix_valid_s = 1'b0;
            busy_s      = 1'b0;
            pix_index_s = 6'd0;
            pix_out_s   = 8'd0;
         end
      endcase
   end

   // State, position, captured image and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         row_r     <= 3'd1;
         col_r     <= 4'd1;
         img_r     <= '0;
         pix_out   <= 8'd0;
         pix_valid <= 1'b0;
         pix_index <= 6'd0;
         busy      <= 1'b0;
         Done      <= 1'b0;
      end else begin
         state_r   <= state_s;
         row_r     <= row_s;
         col_r     <= col_s;
         img_r     <= capture_s ? rows_s : img_r;
         pix_out   <= pix_out_s;
         pix_valid <= pix_valid_s;
         pix_index <= pix_index_s;
         busy      <= busy_s;
         Done      <= done_s;
      end
   end
endmodule

// File: tb/tb_image_reconstructor.sv
// Scoreboard bench for image_reconstructor: table of spot pixel values plus
// hand-written stall, glitch, random-ready and mid-frame reset sequences.
module tb_image_reconstructor;
   logic       clk = 1'b0;
   logic       reset, Go, pix_ready;
   logic [1:8] r1, r2, r3, r4, r5, r6;
   logic [7:0] pix_out;
   logic       pix_valid, busy, Done;
   logic [5:0] pix_index;

   image_reconstructor dut (
      .clk(clk), .reset(reset), .Go(Go),
      .HTPV_Row_1(r1), .HTPV_Row_2(r2), .HTPV_Row_3(r3),
      .HTPV_Row_4(r4), .HTPV_Row_5(r5), .HTPV_Row_6(r6),
      .pix_ready(pix_ready), .pix_out(pix_out), .pix_valid(pix_valid),
      .pix_index(pix_index), .busy(busy), .Done(Done)
   );

   always #5 clk = ~clk;

   typedef struct { logic [5:0] idx; logic [7:0] val; } exp_t;
   typedef struct { logic [1:6][1:8] img; int idx; logic [7:0] exp_off; logic [7:0] exp_on; } vec_t;

   localparam logic [1:6][1:8] ALL1 = {6{8'hFF}};
   localparam logic [1:6][1:8] ALL0 = {6{8'h00}};
   localparam logic [1:6][1:8] PAT  = {{3{8'b11110000}}, {3{8'b00001111}}};
   localparam logic [1:6][1:8] CHK  = {{3{8'hAA, 8'h55}}};

   exp_t       sb[$];
   vec_t       vt [0:11];
   logic [7:0] obs [1:48];
   int         tests = 0, fails = 0;
   int         done_cnt, first_v, last_v, done_at;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [1:6][1:8] img, input int r, input int c);
`ifdef RECON_FILTER_EN
      int k = 0;
      int n = 0;
      for (int rr = r - 1; rr <= r + 1; rr++)
         for (int cc = c - 1; cc <= c + 1; cc++)
            if (rr >= 1 && rr <= 6 && cc >= 1 && cc <= 8) begin
               n++;
               if (img[rr][cc]) k++;
            end
      return 8'((255 * k) / n);
`else
      return img[r][c] ? 8'd255 : 8'd0;
`endif
   endfunction

   task automatic sample();
      exp_t e;
      if (pix_valid) begin
         check("busy_in_scan", busy, 1);
         if (sb.size() == 0) begin
            check("unexpected_pixel", 0, 1);
         end else begin
            e = sb[0];
            check("pix_index", pix_index, e.idx);
            check("pix_out", pix_out, e.val);
            if (pix_ready) begin
               obs[e.idx] = pix_out;
               e = sb.pop_front();
            end
         end
      end else begin
         check("zero_when_invalid", {pix_out, pix_index}, 0);
         check("busy_when_invalid", busy, 0);
      end
      if (Done) done_cnt++;
   endtask

   task automatic cycle();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rows(input logic [1:6][1:8] img);
      {r1, r2, r3, r4, r5, r6} = img;
   endtask

   task automatic push_frame(input logic [1:6][1:8] img);
      exp_t e;
      for (int p = 1; p <= 48; p++) begin
         e.idx = 6'(p);
         e.val = model(img, (p - 1) / 8 + 1, (p - 1) % 8 + 1);
         sb.push_back(e);
      end
   endtask

   // mode 1 = random ready; stall_at/glitch_at 0 = off; exp_last 0 = skip cycle-exact timing.
   task automatic run_frame(input logic [1:6][1:8] img, input int mode, input int stall_at,
                            input int glitch_at, input int exp_last);
      int stall_left = 0;
      bit stalled = 1'b0;
      set_rows(img);
      Go = 1'b1;
      pix_ready = 1'b1;
      push_frame(img);
      done_cnt = 0; first_v = 0; last_v = 0; done_at = 0;
      cycle();
      Go = 1'b0;
      for (int i = 1; i <= 400 && done_at == 0; i++) begin
         @(negedge clk);
         if (pix_valid && first_v == 0) first_v = i;
         if (pix_valid) last_v = i;
         if (Done && done_at == 0) done_at = i;
         sample();
         @(posedge clk);
         #1;
         if (glitch_at != 0 && i == glitch_at) begin
            Go = 1'b1;
            set_rows(~img);
         end else if (glitch_at != 0 && i == glitch_at + 1) begin
            Go = 1'b0;
         end
         if (stall_at != 0 && !stalled && pix_valid && pix_index == 6'(stall_at)) begin
            stalled = 1'b1;
            stall_left = 3;
         end
         if (stall_left > 0) begin
            pix_ready = 1'b0;
            stall_left--;
         end else begin
            pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
      pix_ready = 1'b1;
      repeat (3) cycle();
      check("done_seen", int'(done_at != 0), 1);
      check("done_pulses", done_cnt, 1);
      check("sb_drained", sb.size(), 0);
      if (exp_last != 0) begin
         check("first_valid_cycle", first_v, 1);
         check("last_valid_cycle", last_v, exp_last);
         check("done_cycle", done_at, exp_last + 1);
      end
      sb.delete();
   endtask

   initial begin
      vt[0]  = '{ALL1, 1,  8'd255, 8'd255};
      vt[1]  = '{ALL1, 48, 8'd255, 8'd255};
      vt[2]  = '{PAT,  1,  8'd255, 8'd255};
      vt[3]  = '{PAT,  4,  8'd255, 8'd170};
      vt[4]  = '{PAT,  5,  8'd0,   8'd85};
      vt[5]  = '{PAT,  12, 8'd255, 8'd170};
      vt[6]  = '{PAT,  13, 8'd0,   8'd85};
      vt[7]  = '{PAT,  20, 8'd255, 8'd141};
      vt[8]  = '{PAT,  29, 8'd255, 8'd141};
      vt[9]  = '{PAT,  41, 8'd0,   8'd0};
      vt[10] = '{PAT,  48, 8'd255, 8'd255};
      vt[11] = '{ALL0, 24, 8'd0,   8'd0};

      reset = 1'b1; Go = 1'b0; pix_ready = 1'b0;
      set_rows(ALL1);
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", pix_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", Done, 0);
      check("rst_out", pix_out, 0);
      check("rst_index", pix_index, 0);
      reset = 1'b0;
      done_cnt = 0;
      pix_ready = 1'b1;
      repeat (3) cycle();
      check("no_output_without_go", done_cnt, 0);

      for (int v = 0; v < 12; v++) begin
         if (v == 0 || vt[v].img != vt[v - 1].img) run_frame(vt[v].img, 0, 0, 0, 48);
`ifdef RECON_FILTER_EN
         check($sformatf("vec%0d_pix%0d", v, vt[v].idx), obs[vt[v].idx], vt[v].exp_on);
`else
         check($sformatf("vec%0d_pix%0d", v, vt[v].idx), obs[vt[v].idx], vt[v].exp_off);
`endif
      end

      run_frame(PAT, 0, 10, 0, 51);
      run_frame(PAT, 0, 0, 10, 48);
      run_frame(CHK, 1, 0, 0, 0);

      set_rows(PAT);
      Go = 1'b1;
      push_frame(PAT);
      done_cnt = 0;
      cycle();
      Go = 1'b0;
      for (int i = 0; i < 100 && pix_index != 6'd20; i++) cycle();
      check("reach_idx20", pix_index, 20);
      reset = 1'b1;
      #1;
      check("abort_valid", pix_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", Done, 0);
      check("abort_index", pix_index, 0);
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) cycle();
      check("abort_no_done", done_cnt, 0);
      run_frame(PAT, 0, 0, 0, 48);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
